top_apb: RTL and testbench

TOP_APB -- requirements
Module: top_apb

---
 rtl/top_apb_pkg.sv | 13 +
 rtl/top_apb_if.sv | 26 ++
 rtl/apb_slave.sv | 25 ++
 rtl/top_apb.sv | 89 ++++++++
 tb/tb_top_apb.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/top_apb_pkg.sv
// Shared definitions for the APB master/slave slice: default widths and FSM encoding.
package top_apb_pkg;

  localparam int ADDWIDTH_DEF  = 8;
  localparam int DATAWIDTH_DEF = 32;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t IDLE   = 2'd0;
  localparam apb_state_t SETUP  = 2'd1;
  localparam apb_state_t ACCESS = 2'd2;

endpackage

// File: rtl/top_apb_if.sv
// APB bus between the master and one slave; paddr carries only the in-slave word address.
interface top_apb_if #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32
);

  logic                   psel;
  logic                   penable;
  logic                   pready;
  logic [ADDWIDTH-1:0]    paddr;
  logic                   pwrite;
  logic [DATAWIDTH-1:0]   pwdata;
  logic [DATAWIDTH/8-1:0] pstrb;
  logic [DATAWIDTH-1:0]   prdata;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  pready, prdata
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output pready, prdata
  );

endinterface

// File: rtl/apb_slave.sv
// Zero-wait-state APB memory slave with byte strobes; contents are deliberately not reset.
module apb_slave
  import top_apb_pkg::*;
#(
  parameter int ADDWIDTH  = ADDWIDTH_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input logic         pclk,
  top_apb_if.slave    bus
);

  logic [DATAWIDTH-1:0] mem [2**ADDWIDTH];

  always_ff @(posedge pclk) begin
    if (bus.psel && bus.penable && bus.pwrite) begin
      for (int unsigned i = 0; i < DATAWIDTH/8; i++) begin
        if (bus.pstrb[i]) mem[bus.paddr][8*i +: 8] <= bus.pwdata[8*i +: 8];
      end
    end
  end

  assign bus.pready = bus.psel & bus.penable;
  assign bus.prdata = mem[bus.paddr];

endmodule

// File: rtl/top_apb.sv
// APB master FSM with two-slave select decode; PRDATA captures the word of each completed read.
module top_apb
  import top_apb_pkg::*;
#(
  parameter int ADDWIDTH  = ADDWIDTH_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PWRITE,
  input  logic                   transfer,
  input  logic [ADDWIDTH:0]      PADDR,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  output logic [DATAWIDTH-1:0]   PRDATA
);

  apb_state_t             state, state_nxt;
  logic [ADDWIDTH:0]      addr_q;
  logic                   write_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [DATAWIDTH/8-1:0] strb_q;
  logic                   psel1, psel2, penable, pready;

  top_apb_if #(.ADDWIDTH(ADDWIDTH), .DATAWIDTH(DATAWIDTH)) bus1 ();
  top_apb_if #(.ADDWIDTH(ADDWIDTH), .DATAWIDTH(DATAWIDTH)) bus2 ();

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = transfer ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = pready ? (transfer ? SETUP : IDLE) : ACCESS;
      default: state_nxt = IDLE;
    endcase
  end

  assign psel1   = (state != IDLE) && !addr_q[ADDWIDTH];
  assign psel2   = (state != IDLE) &&  addr_q[ADDWIDTH];
  assign penable = (state == ACCESS);
  assign pready  = addr_q[ADDWIDTH] ? bus2.pready : bus1.pready;

  assign bus1.psel    = psel1;
  assign bus1.penable = penable;
  assign bus1.paddr   = addr_q[ADDWIDTH-1:0];
  assign bus1.pwrite  = write_q;
  assign bus1.pwdata  = wdata_q;
  assign bus1.pstrb   = strb_q;

  assign bus2.psel    = psel2;
  assign bus2.penable = penable;
  assign bus2.paddr   = addr_q[ADDWIDTH-1:0];
  assign bus2.pwrite  = write_q;
  assign bus2.pwdata  = wdata_q;
  assign bus2.pstrb   = strb_q;

  // SETUP is only ever entered from IDLE or ACCESS, so state_nxt==SETUP marks each entry.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      PRDATA  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == SETUP) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
      if (penable && pready && !write_q)
        PRDATA <= addr_q[ADDWIDTH] ? bus2.prdata : bus1.prdata;
    end
  end

  apb_slave #(.ADDWIDTH(ADDWIDTH), .DATAWIDTH(DATAWIDTH)) u_slave1 (
    .pclk (PCLK),
    .bus  (bus1.slave)
  );

  apb_slave #(.ADDWIDTH(ADDWIDTH), .DATAWIDTH(DATAWIDTH)) u_slave2 (
    .pclk (PCLK),
    .bus  (bus2.slave)
  );

endmodule

// File: tb/tb_top_apb.sv
// Directed bench for top_apb: byte-strobe writes, reads, back-to-back streaming and reset abort.
module tb_top_apb;
  import top_apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          pclk;
  logic          presetn;
  logic          transfer;
  logic [AW:0]   paddr;
  int            checks   = 0;
  int            failures = 0;

  top_apb_if #(.ADDWIDTH(AW), .DATAWIDTH(DW)) bus ();

  top_apb #(.ADDWIDTH(AW), .DATAWIDTH(DW)) dut (
    .PCLK     (pclk),
    .PRESETn  (presetn),
    .PWRITE   (bus.pwrite),
    .transfer (transfer),
    .PADDR    (paddr),
    .PWDATA   (bus.pwdata),
    .PSTRB    (bus.pstrb),
    .PRDATA   (bus.prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single transfer with transfer dropped during SETUP; returns at the negedge after completion.
  task automatic xfer(input logic [AW:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(negedge pclk);
    transfer   = 1'b1;
    paddr      = a;
    bus.pwrite = w;
    bus.pwdata = d;
    bus.pstrb  = s;
    @(negedge pclk);
    transfer   = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
  endtask

  initial begin
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pready  = 1'b0;
    bus.paddr   = '0;
    presetn     = 1'b0;
    transfer    = 1'b0;
    paddr       = '0;
    bus.pwrite  = 1'b0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    #1;
    chk("reset_prdata", bus.prdata, 32'h0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    chk("reset_psel", {30'b0, dut.psel1, dut.psel2}, 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;

    // Write with phase-by-phase observation of the FSM and bus selects
    @(negedge pclk);
    transfer = 1'b1; paddr = 9'h000; bus.pwrite = 1'b1; bus.pwdata = 32'hCAFEBABE; bus.pstrb = 4'hF;
    @(negedge pclk);
    transfer = 1'b0;
    chk("w1_setup_state", 32'(dut.state), 32'(SETUP));
    chk("w1_setup_sel", {29'b0, dut.psel1, dut.psel2, dut.penable}, 32'b100);
    @(negedge pclk);
    chk("w1_access_state", 32'(dut.state), 32'(ACCESS));
    chk("w1_access_sel", {29'b0, dut.psel1, dut.psel2, dut.penable}, 32'b101);
    @(negedge pclk);
    chk("w1_idle_state", 32'(dut.state), 32'(IDLE));
    chk("w1_idle_sel", {29'b0, dut.psel1, dut.psel2, dut.penable}, 32'b000);

    xfer(9'h000, 1'b0, 32'h0, 4'h0);
    chk("rd_000", bus.prdata, 32'hCAFEBABE);

    xfer(9'h001, 1'b1, 32'hFFFFFFFF, 4'b1010);
    chk("prdata_hold_write", bus.prdata, 32'hCAFEBABE);
    xfer(9'h001, 1'b1, 32'h00EE00EE, 4'b0101);
    xfer(9'h001, 1'b0, 32'h0, 4'hF);
    chk("rd_001_strobes", bus.prdata, 32'hFFEEFFEE);

    xfer(9'h002, 1'b1, 32'h12345678, 4'hF);
    xfer(9'h102, 1'b1, 32'hFFFFCAFE, 4'b0011);
    @(negedge pclk);
    chk("prdata_hold_idle", bus.prdata, 32'hFFEEFFEE);
    xfer(9'h102, 1'b1, 32'hDEADFFFF, 4'b1100);
    xfer(9'h102, 1'b0, 32'h0, 4'h0);
    chk("rd_102_slave2", bus.prdata, 32'hDEADCAFE);
    xfer(9'h002, 1'b0, 32'h0, 4'h0);
    chk("rd_002_slave1_untouched", bus.prdata, 32'h12345678);

    xfer(9'h000, 1'b1, 32'h00000000, 4'h0);
    xfer(9'h000, 1'b0, 32'h0, 4'h0);
    chk("rd_000_zero_strobe", bus.prdata, 32'hCAFEBABE);

    // Three back-to-back reads: SETUP/ACCESS alternate, PRDATA refreshes every two cycles
    @(negedge pclk);
    transfer = 1'b1; paddr = 9'h000; bus.pwrite = 1'b0; bus.pstrb = 4'h0;
    @(negedge pclk);
    chk("b2b_s1", 32'(dut.state), 32'(SETUP));
    paddr = 9'h001;
    @(negedge pclk);
    chk("b2b_a1", 32'(dut.state), 32'(ACCESS));
    @(negedge pclk);
    chk("b2b_s2", 32'(dut.state), 32'(SETUP));
    chk("b2b_rd1", bus.prdata, 32'hCAFEBABE);
    paddr = 9'h102;
    @(negedge pclk);
    chk("b2b_a2", 32'(dut.state), 32'(ACCESS));
    @(negedge pclk);
    chk("b2b_s3", 32'(dut.state), 32'(SETUP));
    chk("b2b_sel3", {30'b0, dut.psel1, dut.psel2}, 32'b01);
    chk("b2b_rd2", bus.prdata, 32'hFFEEFFEE);
    transfer = 1'b0;
    @(negedge pclk);
    chk("b2b_a3", 32'(dut.state), 32'(ACCESS));
    @(negedge pclk);
    chk("b2b_idle", 32'(dut.state), 32'(IDLE));
    chk("b2b_rd3", bus.prdata, 32'hDEADCAFE);

    // Reset asserted in the ACCESS phase of a write abandons it
    xfer(9'h003, 1'b1, 32'h11223344, 4'hF);
    @(negedge pclk);
    transfer = 1'b1; paddr = 9'h003; bus.pwrite = 1'b1; bus.pwdata = 32'hAABBCCDD; bus.pstrb = 4'hF;
    @(negedge pclk);
    transfer = 1'b0;
    @(negedge pclk);
    chk("rst_pre_access", 32'(dut.state), 32'(ACCESS));
    presetn = 1'b0;
    #1;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_prdata", bus.prdata, 32'h0);
    chk("rst_sel", {29'b0, dut.psel1, dut.psel2, dut.penable}, 32'b000);
    @(negedge pclk);
    presetn = 1'b1;
    xfer(9'h003, 1'b0, 32'h0, 4'h0);
    chk("rst_no_write", bus.prdata, 32'h11223344);
    xfer(9'h000, 1'b0, 32'h0, 4'h0);
    chk("mem_survives_reset", bus.prdata, 32'hCAFEBABE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
